// File: rtl/v2f_load_store_unit_pkg.sv
// Shared definitions for the v2f load/store unit: data widths matching the RAM,
// request size encodings, FSM states and the request legality check.
package v2f_load_store_unit_pkg;

  localparam int BYTE_WIDTH = 8;
  localparam int WIDTH      = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  // Illegal size, misalignment for the access size, or a word index past the RAM end.
  function automatic logic req_error(input logic [1:0] size, input logic [31:0] addr,
                                     input int words);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= 32'(words)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/v2f_load_store_unit_align.sv
// Byte-lane steering: replicates store data and builds the write mask, and
// extracts plus sign/zero-extends the addressed lane of a loaded word.
module v2f_load_store_unit_align
  import v2f_load_store_unit_pkg::*;
(
  input  logic [1:0]       st_size,
  input  logic [1:0]       st_lane,
  input  logic [WIDTH-1:0] st_wdata,
  output logic [WIDTH-1:0] wr_data,
  output logic [3:0]       byte_sel,
  input  logic [1:0]       ld_size,
  input  logic [1:0]       ld_lane,
  input  logic             ld_unsigned,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] ld_data
);

  logic [BYTE_WIDTH-1:0]   ld_byte;
  logic [2*BYTE_WIDTH-1:0] ld_half;

  always_comb begin
    wr_data  = st_wdata;
    byte_sel = 4'b1111;
    case (st_size)
      SZ_BYTE: begin
        wr_data  = {4{st_wdata[BYTE_WIDTH-1:0]}};
        byte_sel = 4'b0001 << st_lane;
      end
      SZ_HALF: begin
        wr_data  = {2{st_wdata[2*BYTE_WIDTH-1:0]}};
        byte_sel = 4'b0011 << st_lane;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = rd_data[{ld_lane, 3'b000} +: BYTE_WIDTH];
    ld_half = rd_data[{ld_lane[1], 4'b0000} +: 2*BYTE_WIDTH];
    ld_data = rd_data;
    case (ld_size)
      SZ_BYTE: ld_data = ld_unsigned ? {{(WIDTH-BYTE_WIDTH){1'b0}}, ld_byte}
                                     : {{(WIDTH-BYTE_WIDTH){ld_byte[BYTE_WIDTH-1]}}, ld_byte};
      SZ_HALF: ld_data = ld_unsigned ? {{(WIDTH-2*BYTE_WIDTH){1'b0}}, ld_half}
                                     : {{(WIDTH-2*BYTE_WIDTH){ld_half[2*BYTE_WIDTH-1]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/v2f_load_store_unit.sv
// CPU-side load/store initiator for the v2f programmable RAM. Every output is
// registered; the next value of each is computed in the combinational FSM process.
module v2f_load_store_unit
  import v2f_load_store_unit_pkg::*;
#(
  parameter int ABITS = 2,
  parameter int SIZE  = 4
) (
  input  logic             CLK,
  input  logic             SRST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_WE,
  input  logic [1:0]       REQ_SIZE,
  input  logic             REQ_UNSIGNED,
  input  logic [31:0]      REQ_ADDR,
  input  logic [31:0]      REQ_WDATA,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [31:0]      RSP_RDATA,
  output logic             RSP_ERR,
  output logic             RD_EN,
  output logic [ABITS-1:0] RD_ADDR,
  input  logic [31:0]      RD_DATA,
  output logic             WR_EN,
  output logic [ABITS-1:0] WR_ADDR,
  output logic [31:0]      WR_DATA,
  output logic [3:0]       BYTE_SELECT
);

  lsu_state_e       state, state_d;
  logic [1:0]       size_q, size_d;
  logic [1:0]       lane_q, lane_d;
  logic             uns_q, uns_d;
  logic             req_ready_d, rsp_valid_d, rsp_err_d, rd_en_d, wr_en_d;
  logic [31:0]      rsp_rdata_d, wr_data_d;
  logic [ABITS-1:0] rd_addr_d, wr_addr_d;
  logic [3:0]       byte_sel_d;
  logic [31:0]      st_wr_data, ld_data;
  logic [3:0]       st_byte_sel;

  v2f_load_store_unit_align u_align (
    .st_size    (REQ_SIZE),
    .st_lane    (REQ_ADDR[1:0]),
    .st_wdata   (REQ_WDATA),
    .wr_data    (st_wr_data),
    .byte_sel   (st_byte_sel),
    .ld_size    (size_q),
    .ld_lane    (lane_q),
    .ld_unsigned(uns_q),
    .rd_data    (RD_DATA),
    .ld_data    (ld_data)
  );

  always_ff @(posedge CLK) begin
    if (SRST) begin
      state       <= ST_IDLE;
      size_q      <= '0;
      lane_q      <= '0;
      uns_q       <= 1'b0;
      REQ_READY   <= 1'b0;
      RSP_VALID   <= 1'b0;
      RSP_ERR     <= 1'b0;
      RSP_RDATA   <= '0;
      RD_EN       <= 1'b0;
      RD_ADDR     <= '0;
      WR_EN       <= 1'b0;
      WR_ADDR     <= '0;
      WR_DATA     <= '0;
      BYTE_SELECT <= '0;
    end else begin
      state       <= state_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      uns_q       <= uns_d;
      REQ_READY   <= req_ready_d;
      RSP_VALID   <= rsp_valid_d;
      RSP_ERR     <= rsp_err_d;
      RSP_RDATA   <= rsp_rdata_d;
      RD_EN       <= rd_en_d;
      RD_ADDR     <= rd_addr_d;
      WR_EN       <= wr_en_d;
      WR_ADDR     <= wr_addr_d;
      WR_DATA     <= wr_data_d;
      BYTE_SELECT <= byte_sel_d;
    end
  end

  // Strobes and their address/data default to zero so each is a single-cycle pulse.
  always_comb begin
    state_d     = state;
    size_d      = size_q;
    lane_d      = lane_q;
    uns_d       = uns_q;
    req_ready_d = 1'b0;
    rsp_valid_d = RSP_VALID;
    rsp_err_d   = RSP_ERR;
    rsp_rdata_d = RSP_RDATA;
    rd_en_d     = 1'b0;
    rd_addr_d   = '0;
    wr_en_d     = 1'b0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    byte_sel_d  = '0;
    case (state)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (REQ_VALID && REQ_READY) begin
          req_ready_d = 1'b0;
          size_d      = REQ_SIZE;
          lane_d      = REQ_ADDR[1:0];
          uns_d       = REQ_UNSIGNED;
          if (req_error(REQ_SIZE, REQ_ADDR, SIZE)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (REQ_WE) begin
            state_d    = ST_WRITE;
            wr_en_d    = 1'b1;
            wr_addr_d  = REQ_ADDR[ABITS+1:2];
            wr_data_d  = st_wr_data;
            byte_sel_d = st_byte_sel;
          end else begin
            state_d   = ST_READ;
            rd_en_d   = 1'b1;
            rd_addr_d = REQ_ADDR[ABITS+1:2];
          end
        end
      end
      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = ld_data;
      end
      ST_RESP: begin
        if (RSP_READY) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_v2f_load_store_unit.sv
// Self-checking bench for v2f_load_store_unit: a behavioural RAM plus strobe and
// response scoreboards filled at request time and drained by negedge monitors.
module tb_v2f_load_store_unit;
  import v2f_load_store_unit_pkg::*;

  localparam int ABITS = 2;
  localparam int SIZE  = 4;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [1:0] raddr;
    logic [1:0] waddr;
    logic [31:0] wdata;
    logic [3:0] sel;
    int         cyc;
  } strobe_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic srst, req_valid, req_ready, req_we, req_unsigned, rsp_valid, rsp_ready, rsp_err;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata, wr_data;
  logic rd_en, wr_en;
  logic [ABITS-1:0] rd_addr, wr_addr;
  logic [31:0] rd_data = 32'h0;
  logic [3:0] byte_select;
  logic [31:0] ram [SIZE] = '{default: 32'h0};

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_accept = 0;
  bit mon_on = 1'b0;
  logic prev_valid = 1'b0;
  strobe_t st_q[$];
  rsp_t sb_q[$];

  v2f_load_store_unit #(.ABITS(ABITS), .SIZE(SIZE)) dut (
    .CLK(clk), .SRST(srst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we), .REQ_SIZE(req_size),
    .REQ_UNSIGNED(req_unsigned), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .RD_EN(rd_en), .RD_ADDR(rd_addr), .RD_DATA(rd_data),
    .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .BYTE_SELECT(byte_select)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: byte-masked write and registered read, both one cycle.
  always @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (byte_select[b]) ram[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    if (rd_en) rd_data <= ram[rd_addr];
  end

  // Strobe and response monitors.
  always @(negedge clk) begin
    strobe_t s;
    rsp_t r;
    if (mon_on) begin
      vectors++;
      if (rd_en || wr_en) begin
        if (st_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_strobe: got rd_en=%b wr_en=%b required no strobe", rd_en, wr_en);
        end else begin
          s = st_q.pop_front();
          if ({rd_en, wr_en, rd_addr, wr_addr, wr_data, byte_select, cyc} !==
              {s.rd, s.wr, s.raddr, s.waddr, s.wdata, s.sel, s.cyc}) begin
            miscompares++;
            $display("[TB] FAIL strobe: got rd=%b wr=%b ra=%0d wa=%0d wd=%h sel=%b cyc=%0d required rd=%b wr=%b ra=%0d wa=%0d wd=%h sel=%b cyc=%0d",
                     rd_en, wr_en, rd_addr, wr_addr, wr_data, byte_select, cyc,
                     s.rd, s.wr, s.raddr, s.waddr, s.wdata, s.sel, s.cyc);
          end
        end
      end else if (rd_addr !== '0 || wr_addr !== '0) begin
        miscompares++;
        $display("[TB] FAIL idle_strobe_addr: got rd_addr=%0d wr_addr=%0d required 0", rd_addr, wr_addr);
      end
      if (rsp_valid === 1'b1 && prev_valid !== 1'b1) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d required no response", cyc);
        end else if (cyc !== sb_q[0].cyc) begin
          miscompares++;
          $display("[TB] FAIL rsp_latency: got cycle %0d required cycle %0d", cyc, sb_q[0].cyc);
        end
      end
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1 && sb_q.size() != 0) begin
        vectors++;
        r = sb_q.pop_front();
        if ({rsp_err, rsp_rdata} !== {r.err, r.rdata}) begin
          miscompares++;
          $display("[TB] FAIL rsp_data: got err=%b rdata=%h required err=%b rdata=%h",
                   rsp_err, rsp_rdata, r.err, r.rdata);
        end
      end
    end
    prev_valid = rsp_valid;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion by 100us required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_err, input logic [31:0] exp_rdata,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_sel,
                           input bit track_rsp);
    int guard;
    strobe_t s;
    rsp_t r;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    req_valid = 1'b1;
    req_we = we;
    req_size = size;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wdata;
    last_accept = cyc;
    if (!exp_err) begin
      s.rd = !we;
      s.wr = we;
      s.raddr = we ? 2'd0 : addr[3:2];
      s.waddr = we ? addr[3:2] : 2'd0;
      s.wdata = we ? exp_wdata : 32'h0;
      s.sel = we ? exp_sel : 4'b0000;
      s.cyc = cyc + 1;
      st_q.push_back(s);
    end
    if (track_rsp) begin
      r.err = exp_err;
      r.rdata = exp_rdata;
      r.cyc = cyc + (exp_err ? 1 : (we ? 2 : 3));
      sb_q.push_back(r);
    end
    step();
    req_valid = 1'b0;
    req_we = 1'($urandom);
    req_size = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic settle();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || req_ready !== 1'b1) && guard < 30) begin
      step();
      guard++;
    end
    vectors++;
    if (sb_q.size() != 0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rsp_timeout: got %0d pending responses, req_ready=%b required 0 pending, ready=1",
               sb_q.size(), req_ready);
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    step();
    vectors++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, rd_en, rd_addr, wr_en, wr_addr, wr_data, byte_select} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got ready=%b rv=%b err=%b rdata=%h rd=%b wr=%b wd=%h sel=%b required all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata, rd_en, wr_en, wr_data, byte_select);
    end
    srst = 1'b0;
    step();
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got %b required 1", req_ready);
    end
    mon_on = 1'b1;
  endtask

  task automatic test_word();
    $display("[TB] word store/load");
    drive_req(1'b1, SZ_WORD, 1'b0, 32'h4, 32'hDEADBEEF, 1'b0, 32'h0, 32'hDEADBEEF, 4'b1111, 1'b1);
    settle();
    drive_req(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0, 4'b0, 1'b1);
    settle();
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
      miscompares++;
      $display("[TB] FAIL rsp_drop: got valid=%b err=%b rdata=%h required all 0", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_byte();
    $display("[TB] byte lanes");
    drive_req(1'b1, SZ_WORD, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 32'h0, 4'b1111, 1'b1);
    settle();
    drive_req(1'b1, SZ_BYTE, 1'b0, 32'h6, 32'h12345680, 1'b0, 32'h0, 32'h80808080, 4'b0100, 1'b1);
    settle();
    drive_req(1'b0, SZ_BYTE, 1'b0, 32'h6, 32'h0, 1'b0, 32'hFFFFFF80, 32'h0, 4'b0, 1'b1);
    settle();
    drive_req(1'b0, SZ_BYTE, 1'b1, 32'h6, 32'h0, 1'b0, 32'h00000080, 32'h0, 4'b0, 1'b1);
    settle();
    drive_req(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 1'b0, 32'h00800000, 32'h0, 4'b0, 1'b1);
    settle();
    drive_req(1'b1, SZ_BYTE, 1'b0, 32'hF, 32'h0000007F, 1'b0, 32'h0, 32'h7F7F7F7F, 4'b1000, 1'b1);
    settle();
    drive_req(1'b0, SZ_BYTE, 1'b0, 32'hF, 32'h0, 1'b0, 32'h0000007F, 32'h0, 4'b0, 1'b1);
    settle();
  endtask

  task automatic test_half();
    $display("[TB] half lanes");
    drive_req(1'b1, SZ_HALF, 1'b0, 32'hA, 32'h0000BEEF, 1'b0, 32'h0, 32'hBEEFBEEF, 4'b1100, 1'b1);
    settle();
    drive_req(1'b0, SZ_HALF, 1'b0, 32'hA, 32'h0, 1'b0, 32'hFFFFBEEF, 32'h0, 4'b0, 1'b1);
    settle();
    drive_req(1'b0, SZ_HALF, 1'b1, 32'hA, 32'h0, 1'b0, 32'h0000BEEF, 32'h0, 4'b0, 1'b1);
    settle();
    drive_req(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1'b0, 32'hBEEF0000, 32'h0, 4'b0, 1'b1);
    settle();
  endtask

  task automatic test_errors();
    $display("[TB] error requests");
    drive_req(1'b0, SZ_HALF, 1'b0, 32'h3, 32'h0, 1'b1, 32'h0, 32'h0, 4'b0, 1'b1);
    settle();
    drive_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hCAFEF00D, 1'b1, 32'h0, 32'h0, 4'b0, 1'b1);
    settle();
    drive_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 4'b0, 1'b1);
    settle();
    drive_req(1'b0, SZ_WORD, 1'b0, 32'h2, 32'h0, 1'b1, 32'h0, 32'h0, 4'b0, 1'b1);
    settle();
    drive_req(1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h55, 1'b1, 32'h0, 32'h0, 4'b0, 1'b1);
    settle();
  endtask

  task automatic test_back_to_back();
    int first;
    $display("[TB] back-to-back throughput");
    drive_req(1'b1, SZ_WORD, 1'b0, 32'hC, 32'h11, 1'b0, 32'h0, 32'h11, 4'b1111, 1'b1);
    first = last_accept;
    drive_req(1'b1, SZ_WORD, 1'b0, 32'hC, 32'h22, 1'b0, 32'h0, 32'h22, 4'b1111, 1'b1);
    vectors++;
    if (last_accept - first !== 3) begin
      miscompares++;
      $display("[TB] FAIL store_interval: got %0d cycles required 3", last_accept - first);
    end
    drive_req(1'b0, SZ_WORD, 1'b0, 32'hC, 32'h0, 1'b0, 32'h22, 32'h0, 4'b0, 1'b1);
    first = last_accept;
    drive_req(1'b0, SZ_WORD, 1'b0, 32'hC, 32'h0, 1'b0, 32'h22, 32'h0, 4'b0, 1'b1);
    vectors++;
    if (last_accept - first !== 4) begin
      miscompares++;
      $display("[TB] FAIL load_interval: got %0d cycles required 4", last_accept - first);
    end
    settle();
  endtask

  task automatic test_backpressure();
    int guard;
    $display("[TB] response backpressure");
    drive_req(1'b1, SZ_WORD, 1'b0, 32'h4, 32'hDEADBEEF, 1'b0, 32'h0, 32'hDEADBEEF, 4'b1111, 1'b1);
    settle();
    rsp_ready = 1'b0;
    drive_req(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0, 4'b0, 1'b1);
    guard = 0;
    while (rsp_valid !== 1'b1 && guard < 10) begin
      step();
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL hold_rsp: got valid=%b err=%b rdata=%h ready=%b required 1 0 deadbeef 0",
                 rsp_valid, rsp_err, rsp_rdata, req_ready);
      end
      if (i == 1) begin
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = SZ_WORD;
        req_addr = 32'h0;
        req_wdata = 32'h11111111;
      end else begin
        req_valid = 1'b0;
      end
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    settle();
    drive_req(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'b0, 1'b1);
    settle();
  endtask

  task automatic test_reset_mid();
    logic saw_valid;
    $display("[TB] reset during load");
    drive_req(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 32'h0, 4'b0, 1'b0);
    step();
    srst = 1'b1;
    step();
    vectors++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, rd_en, rd_addr, wr_en, wr_addr, wr_data, byte_select} !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_outputs: got ready=%b rv=%b err=%b rdata=%h rd=%b wr=%b required all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata, rd_en, wr_en);
    end
    srst = 1'b0;
    step();
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_ready: got %b required 1", req_ready);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid !== 1'b0) saw_valid = 1'b1;
      step();
    end
    vectors++;
    if (saw_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL dropped_load: got rsp_valid seen=%b required 0", saw_valid);
    end
    drive_req(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0, 4'b0, 1'b1);
    settle();
  endtask

  initial begin
    srst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b1;
    step();
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    step();
    vectors++;
    if (st_q.size() != 0 || sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL leftover: got %0d strobes, %0d responses pending required 0", st_q.size(), sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
